gba_cart_rom_ctrl: RTL and testbench

GBA_CART_ROM_CTRL -- requirements
Module: gba_cart_rom_ctrl

---
 rtl/gba_cart_rom_ctrl.sv | 149 ++++++++++++++
 tb/tb_gba_cart_rom_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_cart_rom_ctrl.sv
// gba_cart_rom_ctrl: GBA cartridge ROM responder with resynced pins, halfword prefetch and write capture.
module gba_cart_rom_ctrl #(
    parameter int ROM_AW   = 9,
    parameter int SYNC     = 3,
    parameter int OPEN_BUS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cart_cs_n,
    input  logic              cart_rd_n,
    input  logic              cart_wr_n,
    input  logic [7:0]        cart_ah,
    input  logic [15:0]       cart_ad_in,
    output logic [15:0]       cart_ad_out,
    output logic              cart_ad_oe,
    output logic [ROM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    output logic              wr_valid,
    output logic [23:0]       wr_addr,
    output logic [15:0]       wr_data,
    input  logic              wr_ready,
    output logic              wr_overflow
);
    localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, FETCH = 2'd2, READY = 2'd3;

    logic [SYNC-1:0]       cs_q, rd_q, wr_q;
    logic [SYNC-1:0][7:0]  ah_q;
    logic [SYNC-1:0][15:0] ad_q;
    logic [2:0]            gc_q;
    logic                  en, fcs_d, rcs_d, frd_d, rrd_d, rwr_d;
    logic                  fcs_q, rcs_q, frd_q, rrd_q, rwr_q;
    logic [1:0]            st_q, st_d;
    logic [23:0]           adr_q, adr_d, wa_q, wa_d;
    logic                  pq_q, pq_d, ld_q, inr;
    logic [15:0]           dat_q, dat_d, wd_q, wd_d;
    logic                  wv_q, wv_d, ov_q, ov_d;
    logic [7:0]            frc_q;

    // Edges are masked until the shifters have flushed their reset ones,
    // so a bus already active at reset release cannot look like a fresh edge.
    assign en    = gc_q == 3'(SYNC);
    assign fcs_d = en & cs_q[SYNC-1] & ~cs_q[SYNC-2];
    assign rcs_d = en & ~cs_q[SYNC-1] & cs_q[SYNC-2];
    assign frd_d = en & rd_q[SYNC-1] & ~rd_q[SYNC-2];
    assign rrd_d = en & ~rd_q[SYNC-1] & rd_q[SYNC-2];
    assign rwr_d = en & ~wr_q[SYNC-1] & wr_q[SYNC-2];
    assign inr   = adr_q[23:ROM_AW] == '0;

    always_comb begin
        st_d  = st_q;
        adr_d = adr_q;
        pq_d  = pq_q;
        if (rcs_q) begin
            st_d = IDLE;
            pq_d = 1'b0;
        end else if (st_q == IDLE) begin
            st_d = fcs_d ? ADDR : IDLE;
        end else if (fcs_q) begin
            adr_d = {ah_q[SYNC-1], ad_q[SYNC-1]};
            st_d  = FETCH;
            pq_d  = 1'b0;
        end else if (st_q == FETCH) begin
            st_d = READY;
            pq_d = pq_q | rrd_q | rwr_q;
        end else if (st_q == READY && (pq_q | rrd_q | rwr_q)) begin
            adr_d = adr_q + 24'd1;
            st_d  = FETCH;
            pq_d  = 1'b0;
        end
    end

    assign dat_d = ld_q ? mem_rdata
                 : (st_q == FETCH && !inr) ? ((OPEN_BUS != 0) ? adr_q[15:0] : 16'hFFFF)
                 : dat_q;

    always_comb begin
        wv_d = wv_q & ~wr_ready;
        wa_d = wa_q;
        wd_d = wd_q;
        ov_d = 1'b0;
        if (rwr_q && st_q != IDLE) begin
            if (!wv_q || wr_ready) begin
                wv_d = 1'b1;
                wa_d = adr_q;
                wd_d = ad_q[SYNC-1];
            end else begin
                ov_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q  <= '1;
            rd_q  <= '1;
            wr_q  <= '1;
            ah_q  <= '1;
            ad_q  <= '1;
            gc_q  <= '0;
            fcs_q <= 1'b0;
            rcs_q <= 1'b0;
            frd_q <= 1'b0;
            rrd_q <= 1'b0;
            rwr_q <= 1'b0;
            st_q  <= IDLE;
            adr_q <= '0;
            pq_q  <= 1'b0;
            ld_q  <= 1'b0;
            dat_q <= '0;
            wv_q  <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
            ov_q  <= 1'b0;
            frc_q <= '0;
        end else begin
            cs_q  <= {cs_q[SYNC-2:0], cart_cs_n};
            rd_q  <= {rd_q[SYNC-2:0], cart_rd_n};
            wr_q  <= {wr_q[SYNC-2:0], cart_wr_n};
            ah_q  <= {ah_q[SYNC-2:0], cart_ah};
            ad_q  <= {ad_q[SYNC-2:0], cart_ad_in};
            gc_q  <= en ? gc_q : gc_q + 3'd1;
            fcs_q <= fcs_d;
            rcs_q <= rcs_d;
            frd_q <= frd_d;
            rrd_q <= rrd_d;
            rwr_q <= rwr_d;
            st_q  <= st_d;
            adr_q <= adr_d;
            pq_q  <= pq_d;
            ld_q  <= mem_rd;
            dat_q <= dat_d;
            wv_q  <= wv_d;
            wa_q  <= wa_d;
            wd_q  <= wd_d;
            ov_q  <= ov_d;
            frc_q <= frc_q + {7'd0, frd_q};
        end
    end

    assign cart_ad_out = dat_q;
    assign cart_ad_oe  = rst_n & ~cart_cs_n & ~cart_rd_n;
    assign mem_addr    = adr_q[ROM_AW-1:0];
    assign mem_rd      = st_q == FETCH && inr;
    assign wr_valid    = wv_q;
    assign wr_addr     = wa_q;
    assign wr_data     = wd_q;
    assign wr_overflow = ov_q;
endmodule

// File: tb/tb_gba_cart_rom_ctrl.sv
// tb_gba_cart_rom_ctrl: vector table, corner sequences and randomized bursts against a cartridge-level model.
module tb_gba_cart_rom_ctrl;
    localparam int S = 3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cart_cs_n = 1'b1, cart_rd_n = 1'b1, cart_wr_n = 1'b1, wr_ready = 1'b0;
    logic [7:0]  cart_ah = '0;
    logic [15:0] cart_ad_in = '0;
    logic [15:0] cart_ad_out, mem_rdata, ad_out_b, mem_rdata_b, wr_data, wd_b;
    logic [8:0]  mem_addr, mem_addr_b;
    logic [23:0] wr_addr, wa_b;
    logic        cart_ad_oe, mem_rd, wr_valid, wr_overflow, ad_oe_b, mem_rd_b, wv_b, ov_b;

    logic [15:0] rom [512];
    int          pass = 0, total = 0, rd_cnt = 0, ov_cnt = 0, acc_n = 0;
    logic [23:0] acc_a;
    logic [15:0] acc_d;

    gba_cart_rom_ctrl #(.ROM_AW(9), .SYNC(S), .OPEN_BUS(1)) dut (
        .clk(clk), .rst_n(rst_n), .cart_cs_n(cart_cs_n), .cart_rd_n(cart_rd_n), .cart_wr_n(cart_wr_n),
        .cart_ah(cart_ah), .cart_ad_in(cart_ad_in), .cart_ad_out(cart_ad_out), .cart_ad_oe(cart_ad_oe),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_overflow(wr_overflow));

    gba_cart_rom_ctrl #(.ROM_AW(9), .SYNC(S), .OPEN_BUS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cart_cs_n(cart_cs_n), .cart_rd_n(cart_rd_n), .cart_wr_n(cart_wr_n),
        .cart_ah(cart_ah), .cart_ad_in(cart_ad_in), .cart_ad_out(ad_out_b), .cart_ad_oe(ad_oe_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_rdata(mem_rdata_b), .wr_valid(wv_b),
        .wr_addr(wa_b), .wr_data(wd_b), .wr_ready(wr_ready), .wr_overflow(ov_b));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= rom[mem_addr];
        if (mem_rd_b) mem_rdata_b <= rom[mem_addr_b];
    end

    always @(negedge clk) begin
        #2;
        if (mem_rd) rd_cnt++;
        if (wr_overflow) ov_cnt++;
        if (wr_valid && wr_ready) begin
            acc_n++;
            acc_a = wr_addr;
            acc_d = wr_data;
        end
    end

    function automatic logic [15:0] model(input logic [23:0] a, input bit ob);
        return (a < 24'd512) ? rom[a[8:0]] : (ob ? a[15:0] : 16'hFFFF);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [23:0] a);
        cart_ah = a[23:16];
        cart_ad_in = a[15:0];
        cyc(1);
        cart_cs_n = 1'b0;
        cyc(8);
    endtask

    task automatic stop();
        cart_cs_n = 1'b1;
        cyc(8);
    endtask

    task automatic rd_get(output logic [15:0] d, output logic [15:0] db, output logic oe);
        cart_rd_n = 1'b0;
        cyc(2);
        d = cart_ad_out;
        db = ad_out_b;
        oe = cart_ad_oe;
        cart_rd_n = 1'b1;
        cyc(8);
    endtask

    task automatic wr_pulse(input logic [15:0] dv);
        cart_ad_in = dv;
        cart_wr_n = 1'b0;
        cyc(2);
        cart_wr_n = 1'b1;
        cyc(6);
    endtask

    typedef struct {
        logic [23:0] a;
        logic [15:0] e1, e2, e1b;
        int          nf;
    } vec_t;

    initial begin
        vec_t        tv[5];
        logic [15:0] d, db;
        logic        oe;
        logic [6:0]  mr;
        logic [15:0] d5, d6;
        logic [8:0]  ma4;
        int          n0;
        for (int i = 0; i < 512; i++) rom[i] = 16'(i * 16'h03B1 + 16'h0707);
        rom[0] = 16'hC0DE;
        rom[16] = 16'hA5A5;
        rom[17] = 16'h5A5A;
        rom[511] = 16'hBEEF;
        tv[0] = '{24'h000010, 16'hA5A5, 16'h5A5A, 16'hA5A5, 3};
        tv[1] = '{24'h000200, 16'h0200, 16'h0201, 16'hFFFF, 0};
        tv[2] = '{24'hFFFFFF, 16'hFFFF, 16'hC0DE, 16'hFFFF, 2};
        tv[3] = '{24'h0001FF, 16'hBEEF, 16'h0200, 16'hBEEF, 1};
        tv[4] = '{24'h123456, 16'h3456, 16'h3457, 16'hFFFF, 0};

        cart_cs_n = 1'b0;
        cart_rd_n = 1'b0;
        cyc(3);
        chk("rst_ad_out", 32'(cart_ad_out), 32'h0);
        chk("rst_ad_oe", 32'(cart_ad_oe), 32'h0);
        chk("rst_mem_rd", 32'(mem_rd), 32'h0);
        chk("rst_wr_valid", 32'(wr_valid), 32'h0);
        cart_cs_n = 1'b1;
        cart_rd_n = 1'b1;
        cyc(1);
        rst_n = 1'b1;
        cyc(6);

        // First transaction: measure strobe latency from the pin edge.
        cart_ah = 8'h00;
        cart_ad_in = 16'h0010;
        cyc(1);
        cart_cs_n = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            mr[k-1] = mem_rd;
            if (k == S + 1) ma4 = mem_addr;
            if (k == S + 2) d5 = cart_ad_out;
            if (k == S + 3) d6 = cart_ad_out;
        end
        chk("lat_mem_rd", 32'(mr), 32'(7'b1 << S));
        chk("lat_mem_addr", 32'(ma4), 32'h10);
        chk("lat_before", 32'(d5), 32'h0);
        chk("lat_valid", 32'(d6), 32'hA5A5);
        cyc(2);
        rd_get(d, db, oe);
        chk("seq_rd1", 32'(d), 32'hA5A5);
        rd_get(d, db, oe);
        chk("seq_rd2", 32'(d), 32'h5A5A);
        stop();
        chk("oe_idle", 32'(cart_ad_oe), 32'h0);

        for (int i = 0; i < 5; i++) begin
            rd_cnt = 0;
            start(tv[i].a);
            rd_get(d, db, oe);
            chk("tv_rd1", 32'(d), 32'(tv[i].e1));
            chk("tv_rd1_ob0", 32'(db), 32'(tv[i].e1b));
            chk("tv_oe", 32'(oe), 32'h1);
            rd_get(d, db, oe);
            chk("tv_rd2", 32'(d), 32'(tv[i].e2));
            stop();
            chk("tv_fetches", 32'(rd_cnt), 32'(tv[i].nf));
        end

        // RD rises during the first fetch; the increment must not be lost.
        cart_ah = 8'h00;
        cart_ad_in = 16'h0020;
        cyc(1);
        cart_cs_n = 1'b0;
        cart_rd_n = 1'b0;
        cyc(1);
        cart_rd_n = 1'b1;
        cyc(10);
        rd_get(d, db, oe);
        chk("queued_rd", 32'(d), 32'(model(24'h21, 1'b1)));
        stop();

        wr_ready = 1'b0;
        ov_cnt = 0;
        start(24'h000100);
        wr_pulse(16'h1234);
        chk("wr1_valid", 32'(wr_valid), 32'h1);
        chk("wr1_addr", 32'(wr_addr), 32'h100);
        chk("wr1_data", 32'(wr_data), 32'h1234);
        chk("wr1_ovf", 32'(ov_cnt), 32'h0);
        wr_pulse(16'h5678);
        chk("wr2_valid", 32'(wr_valid), 32'h1);
        chk("wr2_data_held", 32'(wr_data), 32'h1234);
        chk("wr2_addr_held", 32'(wr_addr), 32'h100);
        chk("wr2_ovf", 32'(ov_cnt), 32'h1);
        n0 = acc_n;
        wr_ready = 1'b1;
        cyc(1);
        chk("wr_clear", 32'(wr_valid), 32'h0);
        chk("wr_acc_n", 32'(acc_n), 32'(n0 + 1));
        chk("wr_acc_data", 32'(acc_d), 32'h1234);
        wr_pulse(16'h9ABC);
        chk("wr3_addr", 32'(acc_a), 32'h102);
        chk("wr3_data", 32'(acc_d), 32'h9ABC);
        chk("wr3_ovf", 32'(ov_cnt), 32'h1);
        wr_ready = 1'b0;
        stop();

        // Reset lands while the first fetch strobe is high.
        cart_ah = 8'h00;
        cart_ad_in = 16'h0010;
        cyc(1);
        cart_cs_n = 1'b0;
        cart_rd_n = 1'b0;
        cyc(S + 1);
        chk("pre_rst_mem_rd", 32'(mem_rd), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_rd", 32'(mem_rd), 32'h0);
        chk("arst_mem_addr", 32'(mem_addr), 32'h0);
        chk("arst_ad_out", 32'(cart_ad_out), 32'h0);
        chk("arst_ad_oe", 32'(cart_ad_oe), 32'h0);
        chk("arst_wr", {wr_valid, wr_overflow, wr_addr[13:0], wr_data}, 32'h0);
        cyc(3);
        cart_rd_n = 1'b1;
        rst_n = 1'b1;
        rd_cnt = 0;
        cyc(8);
        for (int i = 0; i < 3; i++) rd_get(d, db, oe);
        chk("post_rst_no_rd", 32'(rd_cnt), 32'h0);
        chk("post_rst_ad_out", 32'(cart_ad_out), 32'h0);
        stop();

        wr_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            logic [23:0] a;
            logic [15:0] dv;
            int          n, ef, wk;
            case ($urandom_range(0, 3))
                0: a = 24'($urandom_range(0, 511));
                1: a = 24'($urandom_range(508, 511));
                2: a = 24'($urandom);
                default: a = 24'($urandom_range(32'hFFFFFD, 32'hFFFFFF));
            endcase
            n = $urandom_range(1, 3);
            wk = $urandom_range(0, 1);
            rd_cnt = 0;
            start(a);
            for (int r = 0; r < n; r++) begin
                if (wk == 0) begin
                    rd_get(d, db, oe);
                    chk("rnd_rd", 32'(d), 32'(model(a + 24'(r), 1'b1)));
                    chk("rnd_rd_ob0", 32'(db), 32'(model(a + 24'(r), 1'b0)));
                end else begin
                    dv = 16'($urandom);
                    n0 = acc_n;
                    wr_pulse(dv);
                    chk("rnd_wr_n", 32'(acc_n), 32'(n0 + 1));
                    chk("rnd_wr_addr", 32'(acc_a), 32'(a + 24'(r)));
                    chk("rnd_wr_data", 32'(acc_d), 32'(dv));
                end
            end
            stop();
            ef = 0;
            for (int i = 0; i <= n; i++) if (24'(a + 24'(i)) < 24'd512) ef++;
            chk("rnd_fetches", 32'(rd_cnt), 32'(ef));
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
